thread_lsu: RTL and testbench

//  Per-thread load/store unit; sits upstream of the thread register file and supplies lsu_out.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/lsu_watchdog.sv | 37 +++
 rtl/thread_lsu.sv | 119 +++++++++++
 tb/tb_thread_lsu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the per-thread core pipeline: the scheduler's core
// state and the load/store unit's own state as seen by the scheduler.
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_watchdog.sv
// Access watchdog: cleared when an access starts waiting, counts each waiting
// cycle and flags expiry on the last permitted cycle. TIMEOUT_CYCLES=0 disables it.
module lsu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: issues one LDR/STR per REQUEST phase over a
// valid/ready memory handshake, bounded by a watchdog, and reports its state.
module thread_lsu
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_e           state_q;
  logic                 is_read_q;
  logic                 rd_valid_q, wr_valid_q;
  logic [ADDR_BITS-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic [DATA_BITS-1:0] out_q;
  logic                 error_q;
  logic                 wd_clr, wd_inc, wd_expired;
  logic                 ready_seen;

  assign wd_clr     = enable && (state_q == LSU_REQUESTING);
  assign wd_inc     = enable && (state_q == LSU_WAITING);
  assign ready_seen = is_read_q ? mem_read_ready : mem_write_ready;

  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      is_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      error_q    <= 1'b0;
    end else if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          // A load takes priority when the decoder flags both.
          if (core_state == CORE_REQUEST &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            is_read_q <= decoded_mem_read_enable;
            state_q   <= LSU_REQUESTING;
          end
        end
        LSU_REQUESTING: begin
          if (is_read_q) begin
            rd_valid_q <= 1'b1;
            rd_addr_q  <= ADDR_BITS'(rs);
          end else begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= ADDR_BITS'(rs);
            wr_data_q  <= rt;
          end
          state_q <= LSU_WAITING;
        end
        LSU_WAITING: begin
          // A ready on the expiry cycle still completes the access normally.
          if (ready_seen) begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            if (is_read_q) out_q <= mem_read_data;
            state_q <= LSU_DONE;
          end else if (wd_expired) begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            error_q    <= 1'b1;
            out_q      <= '0;
            state_q    <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) state_q <= LSU_IDLE;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = error_q;

endmodule

// File: tb/tb_thread_lsu.sv
// Scoreboard bench for thread_lsu: the driver plays core and memory and queues
// the expected outcome of each access; an independent monitor checks it at DONE.
module tb_thread_lsu;

  localparam int TO = 6;
  localparam logic [1:0] S_IDLE = 2'b00, S_REQ = 2'b01, S_WAIT = 2'b10, S_DONE = 2'b11;
  localparam logic [2:0] C_IDLE = 3'b000, C_REQUEST = 3'b011, C_WAIT = 3'b100,
                         C_EXECUTE = 3'b101, C_UPDATE = 3'b110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] core_state = C_IDLE;
  logic       rd_en = 1'b0, wr_en = 1'b0;
  logic [7:0] rs = '0, rt = '0;
  logic       mem_read_valid, mem_write_valid;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data;
  logic       mem_read_ready = 1'b0, mem_write_ready = 1'b0;
  logic [7:0] mem_read_data = '0;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  always #5 clk = ~clk;

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .core_state              (core_state),
    .decoded_mem_read_enable (rd_en),
    .decoded_mem_write_enable(wr_en),
    .rs                      (rs),
    .rt                      (rt),
    .mem_read_valid          (mem_read_valid),
    .mem_read_address        (mem_read_address),
    .mem_read_ready          (mem_read_ready),
    .mem_read_data           (mem_read_data),
    .mem_write_valid         (mem_write_valid),
    .mem_write_address       (mem_write_address),
    .mem_write_data          (mem_write_data),
    .mem_write_ready         (mem_write_ready),
    .lsu_state               (lsu_state),
    .lsu_out                 (lsu_out),
    .lsu_error               (lsu_error)
  );

  typedef struct {
    logic       is_write;
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
    logic [7:0] out;
    logic       err;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] model_out = '0;
  logic       model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks each valid burst and scores it when the unit reaches DONE.
  logic       mon_active = 1'b0, mon_write = 1'b0, mon_stable = 1'b1, mon_both = 1'b0;
  logic [7:0] mon_addr = '0, mon_data = '0;
  int         mon_len = 0;
  logic [1:0] mon_prev = S_IDLE;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
      mon_both   = 1'b0;
      mon_prev   = S_IDLE;
    end else begin
      if (mem_read_valid && mem_write_valid) mon_both = 1'b1;
      if ((mem_read_valid || mem_write_valid) && !mon_active) begin
        mon_active = 1'b1;
        mon_write  = mem_write_valid;
        mon_addr   = mem_write_valid ? mem_write_address : mem_read_address;
        mon_data   = mem_write_data;
        mon_len    = 1;
        mon_stable = 1'b1;
      end else if ((mem_read_valid || mem_write_valid) && mon_active) begin
        mon_len++;
        if ((mon_write ? mem_write_address : mem_read_address) != mon_addr) mon_stable = 1'b0;
        if (mon_write && mem_write_data != mon_data) mon_stable = 1'b0;
      end
      if (lsu_state == S_DONE && mon_prev != S_DONE) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 32'(expq.size()), 32'd1);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("req_seen", 32'(mon_active), 32'd1);
          chk("req_kind", 32'(mon_write), 32'(e.is_write));
          chk("req_addr", 32'(mon_addr), 32'(e.addr));
          if (e.is_write) chk("req_wdata", 32'(mon_data), 32'(e.data));
          chk("valid_len", 32'(mon_len), 32'(e.len));
          chk("req_stable", 32'(mon_stable), 32'd1);
          chk("single_valid", 32'(mon_both), 32'd0);
          chk("lsu_out", 32'(lsu_out), 32'(e.out));
          chk("lsu_error", 32'(lsu_error), 32'(e.err));
        end
        mon_active = 1'b0;
        mon_both   = 1'b0;
      end
      mon_prev = lsu_state;
    end
  end

  always @(negedge clk) if (!mem_read_ready) mem_read_data <= 8'($urandom);

  // Wait at negedges until either valid rises; false if it never does.
  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!(mem_read_valid || mem_write_valid) && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = (mem_read_valid || mem_write_valid);
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; core_state = C_REQUEST; rd_en = rd; wr_en = wr; rs = a; rt = d;
    @(posedge clk);
    @(negedge clk);
    core_state = C_WAIT; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // One access; dly = valid cycles before ready (>= TO means memory never answers).
  task automatic do_txn(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int dly, input logic [7:0] rdata);
    exp_t e;
    bit   ok;
    bit   timed_out;
    int   n;
    timed_out  = (dly >= TO);
    e.is_write = !rd;
    e.addr     = a;
    e.data     = d;
    e.len      = timed_out ? TO : dly + 1;
    if (timed_out)  model_out = 8'h00;
    else if (rd)    model_out = rdata;
    model_err  = model_err | timed_out;
    e.out      = model_out;
    e.err      = model_err;
    expq.push_back(e);
    start_req(rd, wr, a, d);
    wait_valid(ok);
    if (!ok) begin
      chk("valid_rise_timeout", 32'd0, 32'd1);
      return;
    end
    if (!timed_out) begin
      repeat (dly) @(negedge clk);
      if (rd) begin mem_read_ready = 1'b1; mem_read_data = rdata; end
      else mem_write_ready = 1'b1;
      @(negedge clk);
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    end
    n = 0;
    while (lsu_state != S_DONE && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (lsu_state != S_DONE) begin
      chk("done_timeout", 32'(lsu_state), 32'(S_DONE));
      return;
    end
    core_state = C_EXECUTE;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    core_state = C_UPDATE;
    @(negedge clk);
    core_state = C_IDLE;
    chk("idle_after_update", 32'(lsu_state), 32'(S_IDLE));
    chk("out_after_update", 32'(lsu_out), 32'(model_out));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_out = '0;
    model_err = 1'b0;
    chk("rst_state", 32'(lsu_state), 32'(S_IDLE));
    chk("rst_rvalid", 32'(mem_read_valid), 32'd0);
    chk("rst_wvalid", 32'(mem_write_valid), 32'd0);
    chk("rst_out", 32'(lsu_out), 32'd0);
    chk("rst_err", 32'(lsu_error), 32'd0);
    chk("rst_raddr", 32'(mem_read_address), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    repeat (2) @(negedge clk);
    apply_reset();

    do_txn(1'b1, 1'b0, 8'h2A, 8'h00, 2, 8'h5C);
    do_txn(1'b0, 1'b1, 8'h10, 8'hEE, 0, 8'h00);
    do_txn(1'b1, 1'b1, 8'h33, 8'h77, 1, 8'hA1);

    // Disabled thread ignores REQUEST; enabled idle unit ignores stray ready.
    @(negedge clk);
    enable = 1'b0; core_state = C_REQUEST; rd_en = 1'b1; rs = 8'h44;
    repeat (3) @(negedge clk);
    chk("dis_state", 32'(lsu_state), 32'(S_IDLE));
    chk("dis_rvalid", 32'(mem_read_valid), 32'd0);
    core_state = C_IDLE; rd_en = 1'b0;
    @(negedge clk);
    enable = 1'b1; mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'hFF;
    repeat (2) @(negedge clk);
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    chk("spur_state", 32'(lsu_state), 32'(S_IDLE));
    chk("spur_out", 32'(lsu_out), 32'(model_out));

    for (int i = 0; i < 40; i++) begin
      logic r, w;
      int   dly;
      r   = 1'($urandom_range(0, 1));
      w   = r ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, TO - 1);
      do_txn(r, w, 8'($urandom), 8'($urandom), dly, 8'($urandom));
    end

    apply_reset();
    do_txn(1'b1, 1'b0, 8'h81, 8'h00, 50, 8'h99);
    do_txn(1'b0, 1'b1, 8'h82, 8'h5A, TO - 1, 8'h00);

    // Reset while an access is waiting abandons it.
    apply_reset();
    start_req(1'b1, 1'b0, 8'h66, 8'h00);
    wait_valid(ok);
    chk("midrst_valid_up", 32'(mem_read_valid), 32'd1);
    @(negedge clk);
    chk("midrst_waiting", 32'(lsu_state), 32'(S_WAIT));
    core_state = C_IDLE;
    apply_reset();

    for (int i = 0; i < 20; i++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      do_txn(r, !r, 8'($urandom), 8'($urandom), $urandom_range(0, TO + 2), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
